wb_ram_banks: RTL and testbench

WB_RAM_BANKS -- requirements
Module: wb_ram_banks

---
 rtl/wb_ram_banks.sv | 170 +++++++++++++++++
 tb/tb_wb_ram_banks.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_banks.sv
// Banked Wishbone RAM with byte-lane writes and a post-reset zero-fill engine.
// Up to four banks share one address, data and strobe set. Each bank is picked
// by its own one-hot CYC bit. Read data is registered and stays on WBs_DAT_o
// until the next read finishes.
module wb_ram_banks #(
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    WBs_CLK_i,
  input  logic                    WBs_RST_i,
  input  logic [ADDR_WIDTH-1:0]   WBs_ADR_i,
  input  logic [NUM_BANKS-1:0]    WBs_CYC_i,
  input  logic [DATA_WIDTH/8-1:0] WBs_BYTE_STB_i,
  input  logic                    WBs_WE_i,
  input  logic                    WBs_STB_i,
  input  logic [DATA_WIDTH-1:0]   WBs_DAT_i,
  output logic [DATA_WIDTH-1:0]   WBs_DAT_o,
  output logic                    WBs_ACK_o,
  output logic                    Init_Busy_o
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned BankW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {StClear, StIdle, StRdWait, StAck} state_e;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][Depth];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [BankW-1:0]      bank_q, bank_d;
  logic [DATA_WIDTH-1:0] rd_pipe_q, rd_pipe_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;

  logic                  req_hit;
  logic [BankW-1:0]      req_bank;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_BANKS-1:0]  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_adr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_dat;

  // Request decode: the lowest set CYC bit wins. The downward loop lets that bank overwrite the rest.
  always_comb begin
    req_bank = '0;
    req_hit  = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (WBs_CYC_i[i]) begin
        req_bank = BankW'(i);
        req_hit  = 1'b1;
      end
    end
    req_hit = req_hit & WBs_STB_i;
    rd_word = mem[req_bank][WBs_ADR_i];
  end

  // Memory write port. The clear engine writes to every bank. No write happens while reset is held.
  always_comb begin
    wr_bank = '0;
    wr_adr  = WBs_ADR_i;
    wr_be   = WBs_BYTE_STB_i;
    wr_dat  = WBs_DAT_i;
    if (!WBs_RST_i) begin
      if (state_q == StClear) begin
        wr_bank = '1;
        wr_adr  = clr_cnt_q;
        wr_be   = '1;
        wr_dat  = '0;
      end else if (state_q == StIdle && req_hit && WBs_WE_i) begin
        wr_bank[req_bank] = 1'b1;
      end
    end
  end

  // Storage arrays with byte-lane enables. Reset does not touch them.
  always_ff @(posedge WBs_CLK_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < NB; l++) begin
        if (wr_bank[b] && wr_be[l]) begin
          mem[b][wr_adr][l*8 +: 8] <= wr_dat[l*8 +: 8];
        end
      end
    end
  end

  // Controller next state. A write commits at the edge where it is sampled.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    bank_d    = bank_q;
    rd_pipe_d = rd_pipe_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    unique case (state_q)
      StClear: begin
        // The counter stops at its last value, so the idle state finds it at all-ones.
        if (clr_cnt_q == '1) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (req_hit) begin
          bank_d = req_bank;
          if (WBs_WE_i) begin
            ack_d   = 1'b1;
            state_d = StAck;
          end else if (RD_LATENCY == 2) begin
            rd_pipe_d = rd_word;
            state_d   = StRdWait;
          end else begin
            dat_d   = rd_word;
            ack_d   = 1'b1;
            state_d = StAck;
          end
        end
      end
      StRdWait: begin
        // If the master drops STB or its CYC bit here, the read is abandoned without an ACK.
        if (WBs_STB_i && WBs_CYC_i[bank_q]) begin
          dat_d   = rd_pipe_q;
          ack_d   = 1'b1;
          state_d = StAck;
        end else begin
          state_d = StIdle;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StClear);
  end

  // Controller state and registered outputs.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_cnt_q <= '0;
      bank_q    <= '0;
      rd_pipe_q <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= CLEAR_ON_RESET;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      bank_q    <= bank_d;
      rd_pipe_q <= rd_pipe_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign WBs_DAT_o   = dat_q;
  assign WBs_ACK_o   = ack_q;
  assign Init_Busy_o = busy_q;

endmodule

// File: tb/tb_wb_ram_banks.sv
// Directed bench for wb_ram_banks. The main instance uses RD_LATENCY=1. A second
// instance on the same inputs uses RD_LATENCY=2.
module tb_wb_ram_banks;

  logic        clk;
  logic        rst;
  logic [9:0]  adr;
  logic [1:0]  cyc;
  logic [3:0]  be;
  logic        we;
  logic        stb;
  logic [31:0] din;
  logic [31:0] dat1, dat2;
  logic        ack1, ack2, busy1, busy2;

  int checks   = 0;
  int failures = 0;

  wb_ram_banks #(
    .NUM_BANKS     (2),
    .ADDR_WIDTH    (10),
    .DATA_WIDTH    (32),
    .RD_LATENCY    (1),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut1 (
    .WBs_CLK_i     (clk),
    .WBs_RST_i     (rst),
    .WBs_ADR_i     (adr),
    .WBs_CYC_i     (cyc),
    .WBs_BYTE_STB_i(be),
    .WBs_WE_i      (we),
    .WBs_STB_i     (stb),
    .WBs_DAT_i     (din),
    .WBs_DAT_o     (dat1),
    .WBs_ACK_o     (ack1),
    .Init_Busy_o   (busy1)
  );

  wb_ram_banks #(
    .NUM_BANKS     (2),
    .ADDR_WIDTH    (10),
    .DATA_WIDTH    (32),
    .RD_LATENCY    (2),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut2 (
    .WBs_CLK_i     (clk),
    .WBs_RST_i     (rst),
    .WBs_ADR_i     (adr),
    .WBs_CYC_i     (cyc),
    .WBs_BYTE_STB_i(be),
    .WBs_WE_i      (we),
    .WBs_STB_i     (stb),
    .WBs_DAT_i     (din),
    .WBs_DAT_o     (dat2),
    .WBs_ACK_o     (ack2),
    .Init_Busy_o   (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  cyc;
    logic [9:0]  adr;
    logic [3:0]  be;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int          n;
    int          acks;
    int          acks2;
    logic [31:0] last_rd;

    // we, cyc, adr, be, wdata, expected read data
    vecs[0]  = '{1'b0, 2'b10, 10'h3FF, 4'h0, 32'h0,        32'h00000000};
    vecs[1]  = '{1'b0, 2'b01, 10'h012, 4'h0, 32'h0,        32'h00000000};
    vecs[2]  = '{1'b1, 2'b01, 10'h012, 4'h5, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 10'h012, 4'h0, 32'h0,        32'h00AD00EF};
    vecs[4]  = '{1'b1, 2'b11, 10'h005, 4'hF, 32'h11223344, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 10'h005, 4'h0, 32'h0,        32'h11223344};
    vecs[6]  = '{1'b0, 2'b10, 10'h005, 4'h0, 32'h0,        32'h00000000};
    vecs[7]  = '{1'b1, 2'b10, 10'h005, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{1'b0, 2'b10, 10'h005, 4'h0, 32'h0,        32'h00000000};
    vecs[9]  = '{1'b1, 2'b10, 10'h3FF, 4'hF, 32'hAABBCCDD, 32'h0};
    vecs[10] = '{1'b1, 2'b10, 10'h3FF, 4'h8, 32'h11111111, 32'h0};
    vecs[11] = '{1'b0, 2'b10, 10'h3FF, 4'h0, 32'h0,        32'h11BBCCDD};
    vecs[12] = '{1'b0, 2'b01, 10'h3FF, 4'h0, 32'h0,        32'h00000000};
    vecs[13] = '{1'b0, 2'b11, 10'h012, 4'h0, 32'h0,        32'h00AD00EF};
    vecs[14] = '{1'b0, 2'b01, 10'h007, 4'h0, 32'h0,        32'h12345678};

    rst = 1'b1; stb = 1'b0; we = 1'b0; cyc = 2'b00; be = 4'h0; adr = '0; din = '0;
    tick();
    tick();
    check("rst_ack", {31'b0, ack1}, 32'd0);
    check("rst_dat", dat1, 32'd0);
    check("rst_busy", {31'b0, busy1}, 32'd1);
    check("rst_busy2", {31'b0, busy2}, 32'd1);

    // Start a clear, then reset again partway through it
    rst = 1'b0;
    repeat (500) tick();
    check("mid_clear_busy", {31'b0, busy1}, 32'd1);
    rst = 1'b1;
    tick();
    check("reclear_rst_busy", {31'b0, busy1}, 32'd1);
    check("reclear_rst_ack", {31'b0, ack1}, 32'd0);

    // Hold a write request across the whole restarted clear
    we = 1'b1; stb = 1'b1; cyc = 2'b01; adr = 10'h007; be = 4'hF; din = 32'h12345678;
    rst = 1'b0;
    n = 0;
    acks = 0;
    while (busy1 === 1'b1 && n < 3000) begin
      tick();
      n++;
      if (ack1 === 1'b1) acks++;
    end
    check("clear_cycles", n, 32'd1024);
    check("clear_no_ack", acks, 32'd0);
    tick();
    check("stalled_req_ack", {31'b0, ack1}, 32'd1);
    stb = 1'b0; we = 1'b0;
    tick();
    check("stalled_req_ack_end", {31'b0, ack1}, 32'd0);

    // Single transactions from the table
    last_rd = 32'h0;
    for (int i = 0; i < 15; i++) begin
      we = vecs[i].we; cyc = vecs[i].cyc; adr = vecs[i].adr;
      be = vecs[i].be; din = vecs[i].dat; stb = 1'b1;
      tick();
      check($sformatf("vec%0d_ack", i), {31'b0, ack1}, 32'd1);
      if (!vecs[i].we) last_rd = vecs[i].exp;
      check($sformatf("vec%0d_dat", i), dat1, last_rd);
      stb = 1'b0; we = 1'b0;
      tick();
      check($sformatf("vec%0d_ack_end", i), {31'b0, ack1}, 32'd0);
    end

    // Latency-2 read: ACK arrives two edges after sampling, with the same data
    we = 1'b0; cyc = 2'b01; adr = 10'h012; stb = 1'b1;
    tick();
    check("lat1_ack", {31'b0, ack1}, 32'd1);
    check("lat2_early_ack", {31'b0, ack2}, 32'd0);
    tick();
    check("lat2_ack", {31'b0, ack2}, 32'd1);
    check("lat2_dat", dat2, 32'h00AD00EF);
    stb = 1'b0;
    tick();
    check("lat2_ack_end", {31'b0, ack2}, 32'd0);

    // Latency-2 read abandoned when STB drops: no ACK, output data held
    cyc = 2'b10; adr = 10'h3FF; stb = 1'b1;
    tick();
    check("abort_lat1_dat", dat1, 32'h11BBCCDD);
    stb = 1'b0;
    n = 0;
    repeat (3) begin
      tick();
      if (ack2 === 1'b1) n++;
    end
    check("abort_lat2_no_ack", n, 32'd0);
    check("abort_lat2_dat_hold", dat2, 32'h00AD00EF);

    // STB held high: one access per two-cycle window
    cyc = 2'b01; adr = 10'h012; stb = 1'b1;
    acks = 0;
    acks2 = 0;
    repeat (6) begin
      tick();
      if (ack1 === 1'b1) acks++;
      if (ack2 === 1'b1) acks2++;
    end
    check("held_stb_acks", acks, 32'd3);
    check("held_stb_acks_lat2", acks2, 32'd2);
    stb = 1'b0;
    tick();

    // Read, then a write to the same address: the read returns the old data
    cyc = 2'b01; adr = 10'h012; we = 1'b0; stb = 1'b1;
    tick();
    check("rw_rd_ack", {31'b0, ack1}, 32'd1);
    we = 1'b1; be = 4'hF; din = 32'h0;
    tick();
    check("rw_gap_ack", {31'b0, ack1}, 32'd0);
    tick();
    check("rw_wr_ack", {31'b0, ack1}, 32'd1);
    check("rw_rd_old", dat1, 32'h00AD00EF);
    stb = 1'b0; we = 1'b0;
    tick();
    stb = 1'b1;
    tick();
    check("rw_new_dat", dat1, 32'h00000000);
    stb = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
